waveform_dbuf: RTL and testbench



---
 rtl/waveform_dbuf.sv | 191 +++++++++++++++++++
 tb/tb_waveform_dbuf.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/waveform_dbuf.sv
// Double-buffered waveform store: one bank plays out samples while the other is
// filled from RAM by DMA; the banks exchange once playback is back at index 0.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for refresh_start
// S_READ      | fetching RAM parts into the shadow bank
// S_WAIT_SWAP | shadow bank complete, waiting for playback to sit at index 0
// S_DONE      | new waveform active; refresh_finished held until start drops
module waveform_dbuf #(
    parameter int WORD_WID      = 24,
    parameter int WORD_AMNT_WID = 11,
    parameter int RAM_WID       = 32,
    parameter int RAM_WORD_WID  = 16,
    parameter int RAM_WORD_INCR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [WORD_WID-1:0]      word,
    input  logic                     word_next,
    output logic                     word_ok,
    output logic                     word_last,
    input  logic                     word_rst,
    input  logic                     refresh_start,
    input  logic [RAM_WID-1:0]       start_addr,
    input  logic [WORD_AMNT_WID-1:0] word_amnt,
    output logic                     refresh_finished,
    output logic [RAM_WID-1:0]       ram_dma_addr,
    input  logic [RAM_WORD_WID-1:0]  ram_word,
    output logic                     ram_read,
    input  logic                     ram_valid
);

    localparam int PARTS    = (WORD_WID + RAM_WORD_WID - 1) / RAM_WORD_WID;
    localparam int PART_WID = (PARTS > 1) ? $clog2(PARTS) : 1;
    localparam int DEPTH    = 2 ** WORD_AMNT_WID;
    localparam logic [PART_WID-1:0] LAST_PART = PART_WID'(PARTS - 1);
    localparam logic [RAM_WID-1:0]  ADDR_INCR = RAM_WID'(RAM_WORD_INCR);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT_SWAP, S_DONE} state_t;

    state_t r_state, w_state_next;

    logic [WORD_WID-1:0]      r_mem_a [DEPTH];
    logic [WORD_WID-1:0]      r_mem_b [DEPTH];
    logic [WORD_AMNT_WID-1:0] r_last_a, r_last_b;
    logic                     r_valid_a, r_valid_b;
    logic                     r_active;
    logic                     r_swap_pending;

    logic [WORD_AMNT_WID-1:0] r_amnt, r_wcnt, r_cntr;
    logic [PART_WID-1:0]      r_part;
    logic [WORD_WID-1:0]      r_asm, w_asm_next;
    logic [RAM_WID-1:0]       r_addr;
    logic                     r_ram_read, r_refresh_finished;
    logic [WORD_WID-1:0]      r_word;
    logic                     r_word_ok, r_word_last;

    logic                     w_act_valid, w_issue, w_swap, w_store, w_part_last;
    logic [WORD_AMNT_WID-1:0] w_act_last;
    logic [WORD_WID-1:0]      w_act_word;

    assign w_act_valid = r_active ? r_valid_b : r_valid_a;
    assign w_act_last  = r_active ? r_last_b : r_last_a;
    assign w_act_word  = r_active ? r_mem_b[r_cntr] : r_mem_a[r_cntr];
    assign w_issue     = word_next && !r_word_ok && w_act_valid && !word_rst;
    assign w_swap      = (r_state == S_WAIT_SWAP) && r_swap_pending && !r_word_ok
                         && !w_issue && (r_cntr == '0);
    assign w_store     = (r_state == S_READ) && r_ram_read && ram_valid;
    assign w_part_last = (r_part == LAST_PART);

    // Bits of the top part that land at or above WORD_WID are simply dropped.
    always_comb begin
        w_asm_next = r_asm;
        for (int b = 0; b < WORD_WID; b++) begin
            if ((b / RAM_WORD_WID) == int'(r_part))
                w_asm_next[b] = ram_word[b % RAM_WORD_WID];
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (refresh_start) w_state_next = S_READ;
            S_READ:      if (w_store && w_part_last && (r_wcnt == r_amnt))
                             w_state_next = S_WAIT_SWAP;
            S_WAIT_SWAP: if (w_swap) w_state_next = S_DONE;
            S_DONE:      if (!refresh_start) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_read         <= 1'b0;
            r_addr             <= '0;
            r_amnt             <= '0;
            r_wcnt             <= '0;
            r_part             <= '0;
            r_asm              <= '0;
            r_valid_a          <= 1'b0;
            r_valid_b          <= 1'b0;
            r_last_a           <= '0;
            r_last_b           <= '0;
            r_swap_pending     <= 1'b0;
            r_active           <= 1'b0;
            r_refresh_finished <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (refresh_start) begin
                    r_addr <= start_addr;
                    r_amnt <= word_amnt;
                    r_wcnt <= '0;
                    r_part <= '0;
                    if (r_active) r_valid_a <= 1'b0;
                    else          r_valid_b <= 1'b0;
                end
                S_READ: begin
                    if (!r_ram_read) begin
                        r_ram_read <= 1'b1;
                    end else if (ram_valid) begin
                        r_ram_read <= 1'b0;
                        r_addr     <= r_addr + ADDR_INCR;
                        r_asm      <= w_asm_next;
                        if (w_part_last) begin
                            r_part <= '0;
                            if (r_wcnt == r_amnt) begin
                                r_swap_pending <= 1'b1;
                                if (r_active) begin
                                    r_valid_a <= 1'b1;
                                    r_last_a  <= r_amnt;
                                end else begin
                                    r_valid_b <= 1'b1;
                                    r_last_b  <= r_amnt;
                                end
                            end else begin
                                r_wcnt <= r_wcnt + WORD_AMNT_WID'(1);
                            end
                        end else begin
                            r_part <= r_part + PART_WID'(1);
                        end
                    end
                end
                S_WAIT_SWAP: if (w_swap) begin
                    r_active           <= ~r_active;
                    r_swap_pending     <= 1'b0;
                    r_refresh_finished <= 1'b1;
                end
                S_DONE: if (!refresh_start) r_refresh_finished <= 1'b0;
                default: ;
            endcase
        end
    end

    // Bank storage carries no reset; the valid flags gate every read.
    always_ff @(posedge clk) begin
        if (!rst && w_store && w_part_last) begin
            if (r_active) r_mem_a[r_wcnt] <= w_asm_next;
            else          r_mem_b[r_wcnt] <= w_asm_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || word_rst) begin
            r_word      <= '0;
            r_word_ok   <= 1'b0;
            r_word_last <= 1'b0;
            r_cntr      <= '0;
        end else if (w_issue) begin
            r_word      <= w_act_word;
            r_word_ok   <= 1'b1;
            r_word_last <= (r_cntr == w_act_last);
            r_cntr      <= (r_cntr == w_act_last) ? '0 : r_cntr + WORD_AMNT_WID'(1);
        end else begin
            r_word_ok   <= 1'b0;
        end
    end

    assign word             = r_word;
    assign word_ok          = r_word_ok;
    assign word_last        = r_word_last;
    assign refresh_finished = r_refresh_finished;
    assign ram_dma_addr     = r_addr;
    assign ram_read         = r_ram_read;

endmodule

// File: tb/tb_waveform_dbuf.sv
// Directed bench for waveform_dbuf: default 24-bit instance plus a 40-bit
// instance to exercise three-part words with truncation of the top part.
module tb_waveform_dbuf;

    logic        clk;
    logic        rst;
    logic [23:0] word;
    logic        word_next, word_ok, word_last, word_rst;
    logic        refresh_start, refresh_finished;
    logic [31:0] start_addr, ram_dma_addr;
    logic [10:0] word_amnt;
    logic [15:0] ram_word;
    logic        ram_read, ram_valid;

    logic [39:0] word2;
    logic        word_next2, word_ok2, word_last2, word_rst2;
    logic        refresh_start2, refresh_finished2;
    logic [31:0] start_addr2, ram_dma_addr2;
    logic [1:0]  word_amnt2;
    logic [15:0] ram_word2;
    logic        ram_read2, ram_valid2;

    logic [15:0] ram_tbl [0:31];
    int n_assert = 0;
    int n_fail   = 0;

    waveform_dbuf dut (
        .clk(clk), .rst(rst), .word(word), .word_next(word_next), .word_ok(word_ok),
        .word_last(word_last), .word_rst(word_rst), .refresh_start(refresh_start),
        .start_addr(start_addr), .word_amnt(word_amnt), .refresh_finished(refresh_finished),
        .ram_dma_addr(ram_dma_addr), .ram_word(ram_word), .ram_read(ram_read),
        .ram_valid(ram_valid)
    );

    waveform_dbuf #(.WORD_WID(40), .WORD_AMNT_WID(2)) dut2 (
        .clk(clk), .rst(rst), .word(word2), .word_next(word_next2), .word_ok(word_ok2),
        .word_last(word_last2), .word_rst(word_rst2), .refresh_start(refresh_start2),
        .start_addr(start_addr2), .word_amnt(word_amnt2), .refresh_finished(refresh_finished2),
        .ram_dma_addr(ram_dma_addr2), .ram_word(ram_word2), .ram_read(ram_read2),
        .ram_valid(ram_valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Acts as the RAM: answers every read request with the next table entry.
    task automatic do_refresh(input bit sel, input logic [31:0] base, input int nreads,
                              input int toff, input bit drop_early);
        int k = 0;
        int cyc = 0;
        @(negedge clk);
        if (sel) begin start_addr2 = base; refresh_start2 = 1'b1; end
        else     begin start_addr  = base; refresh_start  = 1'b1; end
        while (k < nreads && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if ((sel ? ram_read2 : ram_read) === 1'b1) begin
                chk($sformatf("dma_addr[%0d]", k), 64'(sel ? ram_dma_addr2 : ram_dma_addr),
                    64'(base + 32'(2 * k)));
                if (sel) begin ram_valid2 = 1'b1; ram_word2 = ram_tbl[toff + k]; end
                else     begin ram_valid  = 1'b1; ram_word  = ram_tbl[toff + k]; end
                k++;
                if (drop_early) begin refresh_start = 1'b0; refresh_start2 = 1'b0; end
            end else begin
                ram_valid = 1'b0; ram_valid2 = 1'b0;
            end
        end
        if (k < nreads) chk("refresh_read_budget", 64'(k), 64'(nreads));
        @(negedge clk);
        ram_valid = 1'b0; ram_valid2 = 1'b0;
    endtask

    task automatic wait_fin(input bit sel, input string tag);
        int cyc = 0;
        while ((sel ? refresh_finished2 : refresh_finished) !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, 64'(sel ? refresh_finished2 : refresh_finished), 64'(1));
    endtask

    task automatic req(input bit sel, input logic [39:0] exp_word, input bit exp_last,
                       input string tag);
        if (sel) word_next2 = 1'b1; else word_next = 1'b1;
        @(negedge clk);
        word_next = 1'b0; word_next2 = 1'b0;
        chk({tag, "_ok"},   64'(sel ? word_ok2 : word_ok), 64'(1));
        chk({tag, "_word"}, 64'(sel ? word2 : 40'(word)), 64'(exp_word));
        chk({tag, "_last"}, 64'(sel ? word_last2 : word_last), 64'(exp_last));
        @(negedge clk);
        chk({tag, "_ok_drop"}, 64'(sel ? word_ok2 : word_ok), 64'(0));
        chk({tag, "_hold"},    64'(sel ? word2 : 40'(word)), 64'(exp_word));
    endtask

    initial begin
        int cyc;
        ram_tbl = '{16'h1111, 16'h0022, 16'h2222, 16'h0044, 16'h3333, 16'h0066, 16'h4444, 16'h0088,
                    16'hAAAA, 16'h00BB, 16'hCCCC, 16'h00DD, 16'h1234, 16'h0056, 16'hFFFF, 16'hFFFF,
                    16'h1234, 16'h5678, 16'hABCD, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        rst = 1'b1;
        word_next = 0; word_rst = 0; refresh_start = 0; start_addr = 0; word_amnt = 0;
        ram_word = 0; ram_valid = 0;
        word_next2 = 0; word_rst2 = 0; refresh_start2 = 0; start_addr2 = 0; word_amnt2 = 0;
        ram_word2 = 0; ram_valid2 = 0;
        repeat (3) @(negedge clk);
        chk("rst_word", 64'(word), 64'(0));
        chk("rst_word_ok", 64'(word_ok), 64'(0));
        chk("rst_word_last", 64'(word_last), 64'(0));
        chk("rst_refresh_finished", 64'(refresh_finished), 64'(0));
        chk("rst_ram_read", 64'(ram_read), 64'(0));
        chk("rst_ram_dma_addr", 64'(ram_dma_addr), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // No bank valid yet: requests are ignored.
        word_next = 1'b1;
        @(negedge clk);
        word_next = 1'b0;
        chk("no_bank_ok_a", 64'(word_ok), 64'(0));
        @(negedge clk);
        chk("no_bank_ok_b", 64'(word_ok), 64'(0));

        // First load: 4 words, 8 reads from 0x100.
        word_amnt = 11'd3;
        do_refresh(1'b0, 32'h100, 8, 0, 1'b0);
        chk("addr_after_load", 64'(ram_dma_addr), 64'h110);
        wait_fin(1'b0, "fin_first");
        refresh_start = 1'b0;
        @(negedge clk);
        chk("fin_drop_first", 64'(refresh_finished), 64'(0));

        req(1'b0, 40'h221111, 1'b0, "p0");
        req(1'b0, 40'h442222, 1'b0, "p1");
        req(1'b0, 40'h663333, 1'b0, "p2");
        req(1'b0, 40'h884444, 1'b1, "p3");
        req(1'b0, 40'h221111, 1'b0, "p0_wrap");
        req(1'b0, 40'h442222, 1'b0, "p1_wrap");

        // Refresh while playback sits mid-waveform; swap must wait for the wrap.
        do_refresh(1'b0, 32'h200, 8, 8, 1'b0);
        repeat (3) @(negedge clk);
        chk("no_swap_mid_play", 64'(refresh_finished), 64'(0));
        req(1'b0, 40'h663333, 1'b0, "old2");
        req(1'b0, 40'h884444, 1'b1, "old3");
        wait_fin(1'b0, "fin_after_wrap");
        req(1'b0, 40'hBBAAAA, 1'b0, "new0");
        req(1'b0, 40'hDDCCCC, 1'b0, "new1");
        word_rst = 1'b1;
        @(negedge clk);
        word_rst = 1'b0;
        chk("wrst_word", 64'(word), 64'(0));
        chk("wrst_ok", 64'(word_ok), 64'(0));
        chk("wrst_last", 64'(word_last), 64'(0));
        chk("wrst_fsm_untouched", 64'(refresh_finished), 64'(1));
        req(1'b0, 40'hBBAAAA, 1'b0, "after_wrst");
        refresh_start = 1'b0;
        @(negedge clk);
        chk("fin_drop_second", 64'(refresh_finished), 64'(0));

        // Reset while a RAM read is outstanding.
        word_amnt = 11'd1;
        start_addr = 32'h300;
        refresh_start = 1'b1;
        cyc = 0;
        while (ram_read !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_read_reached", 64'(ram_read), 64'(1));
        rst = 1'b1; refresh_start = 1'b0; ram_valid = 1'b1; ram_word = 16'hDEAD;
        @(negedge clk);
        rst = 1'b0; ram_valid = 1'b0;
        chk("rst_mid_ram_read", 64'(ram_read), 64'(0));
        chk("rst_mid_addr", 64'(ram_dma_addr), 64'(0));
        chk("rst_mid_word", 64'(word), 64'(0));
        chk("rst_mid_fin", 64'(refresh_finished), 64'(0));
        word_next = 1'b1;
        @(negedge clk);
        word_next = 1'b0;
        chk("rst_mid_invalid_a", 64'(word_ok), 64'(0));
        @(negedge clk);
        chk("rst_mid_invalid_b", 64'(word_ok), 64'(0));

        // Reload with refresh_start dropped after the first read.
        word_amnt = 11'd3;
        do_refresh(1'b0, 32'h100, 8, 0, 1'b1);
        wait_fin(1'b0, "fin_early_drop");
        req(1'b0, 40'h221111, 1'b0, "reload0");
        chk("fin_pulse_gone", 64'(refresh_finished), 64'(0));

        // 40-bit words from 16-bit reads: 3 parts, top byte of part 2 dropped.
        word_amnt2 = 2'd0;
        do_refresh(1'b1, 32'h40, 3, 16, 1'b0);
        wait_fin(1'b1, "fin_w40");
        req(1'b1, 40'hCD56781234, 1'b1, "w40_a");
        req(1'b1, 40'hCD56781234, 1'b1, "w40_b");
        refresh_start2 = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
